// File: rtl/iob_regfile_sp_ctrl_pkg.sv
// Shared definitions for the regfile command sequencer: op codes, FSM state
// encodings and the command length decode.
package iob_regfile_sp_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_DUMP  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_e;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD     = 3'd1;
  localparam logic [ST_W-1:0] ST_DUMP_RD  = 3'd2;
  localparam logic [ST_W-1:0] ST_DUMP_OUT = 3'd3;
  localparam logic [ST_W-1:0] ST_CLEAR    = 3'd4;

  // A zero length means "the whole regfile" starting from the command address.
  function automatic logic [15:0] decode_len(input logic [15:0] len, input int unsigned addr_w);
    decode_len = (len == 16'd0) ? (16'd1 << addr_w) : len;
  endfunction

endpackage

// File: rtl/iob_regfile_sp_ctrl_if.sv
// Command, load-stream and dump-stream bundle between a host and the sequencer.
interface iob_regfile_sp_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    // All three channels: a word moves on a rising clock edge where valid and
    // ready are both high; valid never waits on ready, and a source holds its
    // payload stable while valid is high and ready is low.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/iob_regfile_sp.sv
// Single-port register file: synchronous write, registered read (data valid
// one cycle after the address).
module iob_regfile_sp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic [DATA_W-1:0] r_data_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] r_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= w_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= mem_q[addr_i];
        end
    end

    assign r_data_o = r_data_q;
endmodule

// File: rtl/iob_regfile_sp_ctrl.sv
// Command sequencer that owns the regfile port: bulk LOAD from a stream, DUMP
// to a stream, or CLEAR an address range, with modulo address wrap.
module iob_regfile_sp_ctrl
    import iob_regfile_sp_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    iob_regfile_sp_ctrl_if.slave  bus,
    output logic                  rf_we_o,
    output logic [ADDR_W-1:0]     rf_addr_o,
    output logic [DATA_W-1:0]     rf_w_data_o,
    input  logic [DATA_W-1:0]     rf_r_data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ST_W-1:0]       state_o
);
    localparam int REM_W = ADDR_W + 1;

    logic [ST_W-1:0]   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic              cmd_take;
    logic              in_hs;
    logic              out_hs;
    logic              last;

    always_comb begin
        cmd_take = (state_q == ST_IDLE) && !done_q && bus.cmd_valid;
        in_hs    = (state_q == ST_LOAD) && bus.in_valid;
        out_hs   = (state_q == ST_DUMP_OUT) && bus.out_ready;
        last     = (rem_q == REM_W'(1));
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_take) begin
                    // A no-op leaves the counters alone so rf_addr stays put.
                    if (cmd_op_e'(bus.cmd_op) != OP_NOP) begin
                        addr_d = bus.cmd_addr;
                        rem_d  = REM_W'(decode_len(16'(bus.cmd_len), ADDR_W));
                    end
                    case (cmd_op_e'(bus.cmd_op))
                        OP_LOAD:  state_d = ST_LOAD;
                        OP_DUMP:  state_d = ST_DUMP_RD;
                        OP_CLEAR: state_d = ST_CLEAR;
                        default:  done_d  = 1'b1;
                    endcase
                end
            end
            ST_LOAD: begin
                if (in_hs) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - REM_W'(1);
                    if (last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DUMP_RD: begin
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                if (out_hs) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - REM_W'(1);
                    state_d = last ? ST_IDLE : ST_DUMP_RD;
                    done_d  = last;
                end
            end
            ST_CLEAR: begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - REM_W'(1);
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // The address is frozen throughout DUMP_OUT and nothing writes during a
    // dump, so the regfile keeps presenting the same word until it is taken.
    assign bus.out_valid = (state_q == ST_DUMP_OUT);
    assign bus.out_data  = bus.out_valid ? rf_r_data_i : '0;
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.cmd_ready = (state_q == ST_IDLE) && !done_q;

    assign rf_we_o     = in_hs || (state_q == ST_CLEAR);
    assign rf_addr_o   = addr_q;
    assign rf_w_data_o = (state_q == ST_LOAD) ? bus.in_data : '0;

    assign busy_o  = (state_q != ST_IDLE);
    assign done_o  = done_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_iob_regfile_sp_ctrl.sv
// Bench for the regfile sequencer wired to a real regfile, checked against a
// plain array model of the regfile contents.
module tb_iob_regfile_sp_ctrl;
  import iob_regfile_sp_ctrl_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iob_regfile_sp_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic [DATA_W-1:0] rf_r_data;
  logic              busy;
  logic              done;
  logic [ST_W-1:0]   state;

  iob_regfile_sp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .rf_we_o     (rf_we),
    .rf_addr_o   (rf_addr),
    .rf_w_data_o (rf_w_data),
    .rf_r_data_i (rf_r_data),
    .busy_o      (busy),
    .done_o      (done),
    .state_o     (state)
  );

  iob_regfile_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (rf_we),
    .addr_i   (rf_addr),
    .w_data_i (rf_w_data),
    .r_data_o (rf_r_data)
  );

  // reference model and scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] load_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [4:0] len);
    return (len == 5'd0) ? DEPTH : int'(len);
  endfunction

  // driver tasks: all start and end just after a falling edge
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [4:0] len);
    int guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'(op != OP_NOP));
    check("cmd_ready_after_accept", 32'(bus.cmd_ready), 32'd0);
  endtask

  task automatic check_done_pulse(input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_cmd_ready_at_done"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_cmd_ready_after"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  // gap_mode 0: in_valid always high, 1: every other cycle, 2: random
  task automatic do_load(input logic [3:0] addr, input logic [4:0] len, input int gap_mode,
                         input int abort_after);
    int n = eff_len(len);
    int i = 0;
    int cyc = 0;
    logic v;
    logic [3:0] a = addr;
    send_cmd(OP_LOAD, addr, len);
    while (i < n && i != abort_after && cyc < 200) begin
      v = (gap_mode == 1) ? (cyc % 2 == 0) : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = v ? load_q[0] : $urandom;
      #1;
      check("load_in_ready", 32'(bus.in_ready), 32'd1);
      check("load_we", 32'(rf_we), 32'(v));
      check("load_no_done", 32'(done), 32'd0);
      if (v) begin
        check("load_addr", 32'(rf_addr), 32'(a));
        check("load_wdata", rf_w_data, load_q[0]);
      end
      @(posedge clk);
      if (v) begin
        model_mem[a] = load_q.pop_front();
        a++;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    if (abort_after < 0) begin
      bus.in_valid = 1'b0;
      check("load_complete", 32'(i), 32'(n));
      check_done_pulse("load");
    end
  endtask

  // stall_mode 0: out_ready at once, 1: ten idle cycles per word with a stray
  // command presented meanwhile, 2: random 0..3 idle cycles
  task automatic do_dump(input logic [3:0] addr, input logic [4:0] len, input int stall_mode);
    int n = eff_len(len);
    int stall;
    logic [3:0] a = addr;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_mem[a]);
      a++;
    end
    a = addr;
    send_cmd(OP_DUMP, addr, len);
    for (int i = 0; i < n; i++) begin
      check("dump_rd_valid", 32'(bus.out_valid), 32'd0);
      check("dump_rd_we", 32'(rf_we), 32'd0);
      check("dump_rd_addr", 32'(rf_addr), 32'(a));
      @(negedge clk);
      stall = (stall_mode == 1) ? 10 : (stall_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int s = 0; s < stall; s++) begin
        bus.out_ready = 1'b0;
        if (stall_mode == 1) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_op    = OP_CLEAR;
          bus.cmd_addr  = a;
          bus.cmd_len   = 5'd1;
        end
        #1;
        check("dump_wait_valid", 32'(bus.out_valid), 32'd1);
        check("dump_wait_stable", bus.out_data, exp_q[0]);
        check("dump_wait_we", 32'(rf_we), 32'd0);
        check("dump_busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      check("dump_valid", 32'(bus.out_valid), 32'd1);
      check("dump_data", bus.out_data, exp_q[0]);
      check("dump_no_done", 32'(done), 32'd0);
      @(posedge clk);
      void'(exp_q.pop_front());
      @(negedge clk);
      bus.out_ready = 1'b0;
      a++;
    end
    check("dump_valid_after", 32'(bus.out_valid), 32'd0);
    check_done_pulse("dump");
  endtask

  task automatic do_clear(input logic [3:0] addr, input logic [4:0] len);
    int n = eff_len(len);
    logic [3:0] a = addr;
    send_cmd(OP_CLEAR, addr, len);
    for (int i = 0; i < n; i++) begin
      check("clear_we", 32'(rf_we), 32'd1);
      check("clear_addr", 32'(rf_addr), 32'(a));
      check("clear_wdata", rf_w_data, 32'd0);
      check("clear_no_done", 32'(done), 32'd0);
      @(posedge clk);
      model_mem[a] = '0;
      a++;
      @(negedge clk);
    end
    check_done_pulse("clear");
  endtask

  task automatic do_nop(input logic [3:0] addr, input logic [4:0] len);
    send_cmd(OP_NOP, addr, len);
    check("nop_we", 32'(rf_we), 32'd0);
    check_done_pulse("nop");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
    check({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
    check({tag, "_rf_w_data"}, rf_w_data, 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, bus.out_data, 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    logic [3:0] ra;
    logic [4:0] rl;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) model_mem[k] = 'x;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // 1: full-depth load 32..47 and full dump
    for (int k = 0; k < 16; k++) load_q.push_back(32'(32 + k));
    do_load(4'd0, 5'd0, 0, -1);
    do_dump(4'd0, 5'd0, 0);

    // 5: clear 4..6 then full dump
    do_clear(4'd4, 5'd3);
    do_dump(4'd0, 5'd0, 0);

    // 2: wrapping load at 14, dump it back, then the wrapped words at 0,1
    for (int k = 0; k < 4; k++) load_q.push_back(32'(100 + k));
    do_load(4'd14, 5'd4, 0, -1);
    do_dump(4'd14, 5'd4, 0);
    do_dump(4'd0, 5'd2, 0);

    // 3: slow consumer with stray commands while busy
    do_dump(4'd0, 5'd0, 1);

    // 4: toggling in_valid
    for (int k = 0; k < 7; k++) load_q.push_back($urandom);
    do_load(4'd3, 5'd7, 1, -1);
    do_dump(4'd0, 5'd0, 2);

    do_nop(4'd9, 5'd5);

    // 6: reset in the middle of a load after three words
    for (int k = 0; k < 8; k++) load_q.push_back($urandom);
    do_load(4'd8, 5'd8, 0, 3);
    bus.in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    check("midreset_no_done", 32'(done), 32'd0);
    bus.in_valid = 1'b0;
    load_q.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("postreset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("postreset_done", 32'(done), 32'd0);
      check("postreset_busy", 32'(busy), 32'd0);
    end
    do_dump(4'd8, 5'd8, 0);

    // random command mix against the model
    for (int t = 0; t < 25; t++) begin
      op = 2'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      rl = 5'($urandom_range(0, 16));
      case (op)
        2'd0: begin
          for (int k = 0; k < eff_len(rl); k++) load_q.push_back($urandom);
          do_load(ra, rl, 2, -1);
        end
        2'd1: do_dump(ra, rl, 2);
        2'd2: do_clear(ra, rl);
        default: do_nop(ra, rl);
      endcase
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 2; k++) begin
          check("idle_we", 32'(rf_we), 32'd0);
          @(negedge clk);
        end
      end
    end
    do_dump(4'd0, 5'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
